// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: pairs ID-stage predictions with EX outcomes,
// raises flush/redirect on mispredict and trains the 2-bit predictor.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pred_valid_i,
    input  logic             pred_taken_i,
    input  logic [PC_W-1:0]  pred_pc_i,
    input  logic             res_valid_i,
    input  logic             res_taken_i,
    input  logic [PC_W-1:0]  res_target_i,
    input  logic             ext_flush_i,
    output logic             update_o,
    output logic             update_taken_o,
    output logic             flush_o,
    output logic [PC_W-1:0]  redirect_pc_o,
    output logic             full_o,
    output logic             err_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [DEPTH-1:0] q_taken;
    logic [PC_W-1:0]  q_pc [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW:0]      count;

    logic             run;
    logic             empty;
    logic             pop;
    logic             push;
    logic             head_taken;
    logic [PC_W-1:0]  head_pc;
    logic             mispred;
    logic             clear;
    logic             push_err;
    logic             pop_err;

    assign run        = (state_q == S_RUN);
    assign empty      = (count == '0);
    assign full_o     = (count == FULL_CNT);
    assign head_taken = q_taken[rd_ptr];
    assign head_pc    = q_pc[rd_ptr];

    // In FLUSH both request inputs belong to the wrong path.
    assign pop      = run & res_valid_i & ~empty;
    assign push     = run & pred_valid_i & (~full_o | pop);
    assign mispred  = pop & (head_taken ^ res_taken_i);
    assign clear    = ext_flush_i | mispred;
    assign push_err = run & pred_valid_i & full_o & ~pop;
    assign pop_err  = run & res_valid_i & empty;

    always_comb begin
        state_d = S_RUN;
        if (!ext_flush_i && mispred)
            state_d = S_FLUSH;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= S_RUN;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_taken <= '0;
            for (int i = 0; i < DEPTH; i++)
                q_pc[i] <= '0;
        end else if (push && !clear) begin
            q_taken[wr_ptr] <= pred_taken_i;
            q_pc[wr_ptr]    <= pred_pc_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            update_o       <= 1'b0;
            update_taken_o <= 1'b0;
            flush_o        <= 1'b0;
        end else begin
            update_o       <= pop;
            update_taken_o <= pop & res_taken_i;
            flush_o        <= mispred;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            redirect_pc_o <= '0;
        else if (mispred)
            redirect_pc_o <= res_taken_i ? res_target_i
                                         : head_pc + PC_W'(4);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            err_o <= 1'b0;
        else if (push_err || pop_err)
            err_o <= 1'b1;
    end

    // Statistics stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            branch_cnt_o <= '0;
            miss_cnt_o   <= '0;
        end else begin
            if (pop && branch_cnt_o != '1)
                branch_cnt_o <= branch_cnt_o + 1'b1;
            if (mispred && miss_cnt_o != '1)
                miss_cnt_o <= miss_cnt_o + 1'b1;
        end
    end

endmodule
